// File: rtl/spi_frame_master.sv
// SPI mode-0 frame master: CS held low across a multi-byte frame, MSB first,
// bytes fed through a valid/ready handshake, plus a slave-interrupt synchroniser.
module spi_frame_master #(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       start,
    input  logic [7:0] frame_len,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       busy,
    output logic       done,
    output logic       SPI_clk,
    output logic       SPI_CS,
    output logic       SPI_SDO,
    input  logic       SPI_SDI,
    input  logic       spi_irq_in,
    output logic       spi_irq
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_XFER,
        ST_HOLD
    } state_t;

    localparam logic [15:0] DIV_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);

    state_t      state_r;
    logic [15:0] cnt_r;
    logic [2:0]  bit_cnt_r;
    logic [7:0]  remaining_r;
    logic [6:0]  tx_sh_r;
    logic [7:0]  rx_sh_r;
    logic        irq_meta_r;

    // Frame sequencer: owns every SPI line and every host-side output.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_r     <= ST_IDLE;
            cnt_r       <= 16'd0;
            bit_cnt_r   <= 3'd0;
            remaining_r <= 8'd0;
            tx_sh_r     <= 7'd0;
            rx_sh_r     <= 8'd0;
            tx_ready    <= 1'b0;
            rx_data     <= 8'd0;
            rx_valid    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            SPI_clk     <= 1'b0;
            SPI_CS      <= 1'b1;
            SPI_SDO     <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            done     <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    SPI_CS   <= 1'b1;
                    SPI_clk  <= 1'b0;
                    SPI_SDO  <= 1'b0;
                    tx_ready <= 1'b0;
                    busy     <= 1'b0;
                    if (start && (frame_len != 8'd0)) begin
                        remaining_r <= frame_len;
                        busy        <= 1'b1;
                        SPI_CS      <= 1'b0;
                        cnt_r       <= 16'd0;
                        state_r     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (cnt_r == SETUP_LAST) begin
                        cnt_r    <= 16'd0;
                        tx_ready <= 1'b1;
                        state_r  <= ST_LOAD;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_LOAD: begin
                    if (tx_valid && tx_ready) begin
                        tx_sh_r   <= tx_data[6:0];
                        SPI_SDO   <= tx_data[7];
                        bit_cnt_r <= 3'd0;
                        cnt_r     <= 16'd0;
                        tx_ready  <= 1'b0;
                        state_r   <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (cnt_r == DIV_LAST) begin
                        cnt_r <= 16'd0;
                        if (!SPI_clk) begin
                            // Slave shifts on the falling edge, so SDI is stable here.
                            SPI_clk <= 1'b1;
                            rx_sh_r <= {rx_sh_r[6:0], SPI_SDI};
                        end else begin
                            SPI_clk <= 1'b0;
                            if (bit_cnt_r == 3'd7) begin
                                rx_data     <= rx_sh_r;
                                rx_valid    <= 1'b1;
                                remaining_r <= remaining_r - 8'd1;
                                if (remaining_r == 8'd1) begin
                                    state_r <= ST_HOLD;
                                end else begin
                                    tx_ready <= 1'b1;
                                    state_r  <= ST_LOAD;
                                end
                            end else begin
                                bit_cnt_r <= bit_cnt_r + 3'd1;
                                SPI_SDO   <= tx_sh_r[6];
                                tx_sh_r   <= {tx_sh_r[5:0], 1'b0};
                            end
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_r == HOLD_LAST) begin
                        cnt_r   <= 16'd0;
                        SPI_CS  <= 1'b1;
                        SPI_SDO <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    SPI_CS   <= 1'b1;
                    SPI_clk  <= 1'b0;
                    tx_ready <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

    // Two-flop synchroniser for the slave interrupt, independent of the frame FSM.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            irq_meta_r <= 1'b0;
            spi_irq    <= 1'b0;
        end else begin
            irq_meta_r <= spi_irq_in;
            spi_irq    <= irq_meta_r;
        end
    end
endmodule

// File: doc/spi_frame_master.md
Name: spi_frame_master

Overview:
- SPI mode-0 master that drives the four-wire SPI interface of the MTL board's cyclonespi_0 slave from the host-side controller.
- Sends framed multi-byte transactions with CS held low across the frame, MSB first, and returns each received byte.
- Host logic feeds bytes through a valid/ready handshake.
- Also synchronises the slave's interrupt line into the local clock domain.

Parameters:
- CLK_DIV, 4, SCLK half-period in clk_clk cycles (legal range ≥2).
- CS_SETUP, 2, clk_clk cycles from CS falling to the first byte load window.
- CS_HOLD, 2, clk_clk cycles from the last SCLK falling edge to CS rising.

Ports:
- clk_clk  in  1  system clock
- reset_reset  in  1  asynchronous, active-high reset
- start  in  1  begin frame; sampled only in IDLE
- frame_len  in  8  number of bytes in the frame; latched on start; 0 means start is ignored
- tx_data  in  8  next byte to send
- tx_valid  in  1  tx_data valid
- tx_ready  out  1  master can accept tx_data this cycle
- rx_data  out  8  last received byte
- rx_valid  out  1  one-cycle pulse, rx_data updated
- busy  out  1  frame in progress (start accepted up to CS rising)
- done  out  1  one-cycle pulse at end of frame
- SPI_clk  out  1  SCLK, idle low
- SPI_CS  out  1  chip select, active low
- SPI_SDO  out  1  MOSI, connects to slave SPI_SDI
- SPI_SDI  in  1  MISO, from slave SPI_SDO
- spi_irq_in  in  1  slave interrupt, asynchronous to clk_clk
- spi_irq  out  1  spi_irq_in after a 2-flop synchroniser

Behaviour:
- Reset values: SPI_CS=1, SPI_clk=0, SPI_SDO=0, tx_ready=0, rx_data=0, rx_valid=0, busy=0, done=0, spi_irq=0.
- Reset acts asynchronously. Asserting it mid-frame forces CS high and SCLK low immediately, and discards the frame.
- IDLE: CS=1, SCLK=0.
  - start=1 with frame_len≠0 latches remaining=frame_len, sets busy=1 and CS=0 on the next edge, then goes to SETUP.
  - start with frame_len=0 is ignored; no output changes.
- SETUP: counts CS_SETUP cycles, then goes to LOAD.
- LOAD: tx_ready=1, CS stays low, SCLK stays low.
  - On tx_valid&&tx_ready: shift register ← tx_data, SDO ← tx_data[7], bit counter=0, go to XFER.
  - Stalls indefinitely without tx_valid.
- XFER, one bit per 2*CLK_DIV cycles:
  - After CLK_DIV cycles, SCLK rises; SPI_SDI is sampled into the rx shift register on that same cycle.
  - After another CLK_DIV cycles, SCLK falls and SDO shifts to the next bit.
  - After the 8th falling edge: rx_data ← rx shift register, rx_valid pulses for 1 cycle, remaining decrements.
  - If remaining>0, go to LOAD; otherwise go to HOLD.
- HOLD: SCLK=0 for CS_HOLD cycles, then CS=1, busy=0, done=1 for one cycle, go to IDLE.
  - CS is therefore high for at least 1 cycle before any new frame.
- Byte time is exactly 16*CLK_DIV cycles from load to rx_valid, with no extra cycles when tx_valid is already high in LOAD.
- SPI_SDO holds the last transmitted bit after the final byte and returns to 0 in IDLE.
- start while busy=1 is ignored; frame_len changes after acceptance have no effect.
- tx_ready is 0 outside LOAD; tx_valid outside LOAD is ignored and not queued.
- Mode 0 only (CPOL=0, CPHA=0), MSB first, 8-bit bytes; the slave shifts on the SCLK falling edge.
- spi_irq = spi_irq_in delayed by 2 clk_clk edges; it runs independently of the FSM and is also cleared by reset.

Test Plan:
- Loopback (SDI tied to SDO), CLK_DIV=4, frame_len=1, tx_data=0xA5 → exactly 8 SCLK pulses, each 4 cycles high and 4 low. rx_valid pulses once with rx_data=0xA5 at load+64 cycles. done follows after CS_HOLD cycles, then CS rises.
- Slave model returns 0x3C, 0x81, 0xFF for a frame_len=3 frame sending 0x01, 0x02, 0x03 → CS stays low throughout; three rx_valid pulses carry 0x3C, 0x81, 0xFF; the slave sees 0x01, 0x02, 0x03; exactly one done pulse.
- Byte 2 of a 2-byte frame withheld for 20 cycles (tx_valid=0) → SCLK stays low and CS stays low for the stall; transfer resumes on tx_valid; data intact.
- start with frame_len=0, and a second start pulsed mid-frame → no CS activity for the first; the second does not alter the frame; busy stays continuous.
- reset_reset asserted at bit 4 of a byte → CS=1, SCLK=0 and busy=0 asynchronously. No rx_valid and no done pulse. The next frame after reset completes normally.
- spi_irq_in toggled 0→1→0 → spi_irq follows with a 2-cycle delay on each edge.
